sprite_compositor: RTL and testbench

Per-pixel compositor that overlays the player sprite and a parametrised number of car sprites onto the background colour stream, at configurable colour depth. It sits between the background generator and the VGA output pins. It also detects player/car overlap during each frame and reports it once per frame. After a hit, it runs a blinking invulnerability window. It is a 2-stage pipeline with fixed latency and replaces the fixed 4-car, 1-bit-per-channel colour generator.

---
 rtl/sprite_compositor_pkg.sv | 26 ++
 rtl/sprite_hit.sv | 40 ++++
 rtl/sprite_compositor.sv | 164 ++++++++++++++++
 tb/tb_sprite_compositor.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_compositor_pkg.sv
// Shared screen geometry, sprite sizes and small helpers for the sprite compositor.
package sprite_compositor_pkg;

    // Visible raster size
    localparam int H_DISPLAY     = 640;
    localparam int V_DISPLAY     = 480;

    // Sprite box sizes in pixels
    localparam int PLAYER_WIDTH  = 16;
    localparam int PLAYER_HEIGHT = 16;
    localparam int CAR_WIDTH     = 16;
    localparam int CAR_HEIGHT    = 24;

    // Blink counter bit that hides the player while invulnerable (toggles every 4 frames)
    localparam int BLINK_BIT     = 2;

    // Coordinate width and the widened width used for pos + size so 1023 + size never wraps
    localparam int POS_W         = 10;
    localparam int SUM_W         = 11;

    // Width of a car index bus; a single car still gets a 1-bit index
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_hit.sv
// One registered box test: hit when pos <= count < pos + size on both axes.
module sprite_hit
    import sprite_compositor_pkg::*;
#(
    parameter int W = 16,
    parameter int H = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [POS_W-1:0] h_count,
    input  logic [POS_W-1:0] v_count,
    input  logic [POS_W-1:0] pos_x,
    input  logic [POS_W-1:0] pos_y,
    input  logic             en,
    output logic             hit
);

    logic [SUM_W-1:0] x_end;
    logic [SUM_W-1:0] y_end;
    logic             hit_next;

    // Far edges computed one bit wider so a sprite near 1023 does not wrap to column 0
    always_comb begin
        x_end    = {1'b0, pos_x} + SUM_W'(W);
        y_end    = {1'b0, pos_y} + SUM_W'(H);
        hit_next = en
                && ({1'b0, pos_x} <= {1'b0, h_count}) && ({1'b0, h_count} < x_end)
                && ({1'b0, pos_y} <= {1'b0, v_count}) && ({1'b0, v_count} < y_end);
    end

    // Stage-1 register of the box test result
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit <= 1'b0;
        end else begin
            hit <= hit_next;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: player and car sprites over the background stream,
// with per-frame player/car collision reporting and a blinking invulnerability window.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int                     NUM_CARS     = 4,
    parameter int                     COLOR_W      = 1,
    parameter logic [3*COLOR_W-1:0]   PLAYER_RGB   = {{COLOR_W{1'b0}}, {COLOR_W{1'b1}}, {COLOR_W{1'b0}}},
    parameter logic [3*COLOR_W-1:0]   CAR_RGB      = {{COLOR_W{1'b1}}, {COLOR_W{1'b0}}, {COLOR_W{1'b0}}},
    parameter int                     BLINK_FRAMES = 60
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [POS_W-1:0]                h_count,
    input  logic [POS_W-1:0]                v_count,
    input  logic [POS_W-1:0]                player_x,
    input  logic [POS_W-1:0]                player_y,
    input  logic [NUM_CARS*POS_W-1:0]       car_x_bus,
    input  logic [NUM_CARS*POS_W-1:0]       car_y_bus,
    input  logic [NUM_CARS-1:0]             car_en,
    input  logic [3*COLOR_W-1:0]            bg_rgb,
    output logic [3*COLOR_W-1:0]            vga_rgb,
    output logic                            collision,
    output logic [idx_width(NUM_CARS)-1:0]  collision_idx,
    output logic                            invuln
);

    localparam int IDX_W = idx_width(NUM_CARS);

    // Stage-1 state
    logic                   player_hit_reg;
    logic [NUM_CARS-1:0]    car_hit_reg;
    logic                   visible_reg;
    logic                   frame_end_reg;
    logic [3*COLOR_W-1:0]   bg_reg;

    // Stage-2 state
    logic [3*COLOR_W-1:0]   vga_rgb_reg;
    logic                   collision_reg;
    logic [IDX_W-1:0]       collision_idx_reg;
    logic [7:0]             blink_cnt_reg;
    logic                   hit_flag_reg;
    logic [IDX_W-1:0]       hit_idx_reg;

    // Stage-2 combinational decisions
    logic                   car_any;
    logic [IDX_W-1:0]       car_low;
    logic                   player_shown;
    logic                   hit_now;
    logic [3*COLOR_W-1:0]   rgb_next;

    // Player box test, always enabled
    sprite_hit #(
        .W (PLAYER_WIDTH),
        .H (PLAYER_HEIGHT)
    ) u_player_hit (
        .CLK     (CLK),
        .RST     (RST),
        .h_count (h_count),
        .v_count (v_count),
        .pos_x   (player_x),
        .pos_y   (player_y),
        .en      (1'b1),
        .hit     (player_hit_reg)
    );

    // One box test per car; a disabled car never reports a hit, so it is neither drawn nor collided
    generate
        for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car
            sprite_hit #(
                .W (CAR_WIDTH),
                .H (CAR_HEIGHT)
            ) u_car_hit (
                .CLK     (CLK),
                .RST     (RST),
                .h_count (h_count),
                .v_count (v_count),
                .pos_x   (car_x_bus[gi*POS_W +: POS_W]),
                .pos_y   (car_y_bus[gi*POS_W +: POS_W]),
                .en      (car_en[gi]),
                .hit     (car_hit_reg[gi])
            );
        end
    endgenerate

    // Stage 1: visible-area flag, frame-end marker and background aligned with the hit vector
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            visible_reg   <= 1'b0;
            frame_end_reg <= 1'b0;
            bg_reg        <= '0;
        end else begin
            visible_reg   <= (h_count < POS_W'(H_DISPLAY)) && (v_count < POS_W'(V_DISPLAY));
            frame_end_reg <= (h_count == '0) && (v_count == POS_W'(V_DISPLAY));
            bg_reg        <= bg_rgb;
        end
    end

    // Priority encoder: lowest-index car wins; player hidden on odd blink phases while invulnerable
    always_comb begin
        car_any      = |car_hit_reg;
        car_low      = '0;
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            if (car_hit_reg[i]) begin
                car_low = IDX_W'(i);
            end
        end
        player_shown = !(invuln && blink_cnt_reg[BLINK_BIT]);
        hit_now      = visible_reg && player_hit_reg && car_any && !invuln;

        if (!visible_reg) begin
            rgb_next = '0;
        end else if (player_hit_reg && player_shown) begin
            rgb_next = PLAYER_RGB;
        end else if (car_any) begin
            rgb_next = CAR_RGB;
        end else begin
            rgb_next = bg_reg;
        end
    end

    // Stage 2: registered output colour
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vga_rgb_reg <= '0;
        end else begin
            vga_rgb_reg <= rgb_next;
        end
    end

    // Stage 2: collision tracker -- sticky hit flag in frame, report and blink reload at frame end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            collision_reg     <= 1'b0;
            collision_idx_reg <= '0;
            blink_cnt_reg     <= '0;
            hit_flag_reg      <= 1'b0;
            hit_idx_reg       <= '0;
        end else begin
            collision_reg <= 1'b0;
            if (frame_end_reg) begin
                // Frame end lies outside the visible area, so no new hit competes with it
                if (hit_flag_reg) begin
                    collision_reg     <= 1'b1;
                    collision_idx_reg <= hit_idx_reg;
                    hit_flag_reg      <= 1'b0;
                    blink_cnt_reg     <= 8'(BLINK_FRAMES);
                end else if (blink_cnt_reg != '0) begin
                    blink_cnt_reg <= blink_cnt_reg - 8'd1;
                end
            end else if (hit_now && !hit_flag_reg) begin
                // Only the first hit of the frame selects the reported car
                hit_flag_reg <= 1'b1;
                hit_idx_reg  <= car_low;
            end
        end
    end

    assign vga_rgb       = vga_rgb_reg;
    assign collision     = collision_reg;
    assign collision_idx = collision_idx_reg;
    assign invuln        = (blink_cnt_reg != '0);

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised self-checking bench for sprite_compositor against a frame-level reference model.
module tb_sprite_compositor;
    import sprite_compositor_pkg::*;

    localparam int NC = 4;
    localparam int BF = 8;
    localparam logic [2:0] P_RGB = 3'b010;
    localparam logic [2:0] C_RGB = 3'b100;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic [9:0]     h_count = '0;
    logic [9:0]     v_count = '0;
    logic [9:0]     player_x = '0;
    logic [9:0]     player_y = '0;
    logic [NC*10-1:0] car_x_bus = '0;
    logic [NC*10-1:0] car_y_bus = '0;
    logic [NC-1:0]  car_en = '0;
    logic [2:0]     bg_rgb = '0;
    logic [2:0]     vga_rgb;
    logic           collision;
    logic [1:0]     collision_idx;
    logic           invuln;

    sprite_compositor #(
        .NUM_CARS     (NC),
        .COLOR_W      (1),
        .PLAYER_RGB   (P_RGB),
        .CAR_RGB      (C_RGB),
        .BLINK_FRAMES (BF)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .h_count       (h_count),
        .v_count       (v_count),
        .player_x      (player_x),
        .player_y      (player_y),
        .car_x_bus     (car_x_bus),
        .car_y_bus     (car_y_bus),
        .car_en        (car_en),
        .bg_rgb        (bg_rgb),
        .vga_rgb       (vga_rgb),
        .collision     (collision),
        .collision_idx (collision_idx),
        .invuln        (invuln)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Bench-side sprite placement
    int px, py;
    int cx [NC];
    int cy [NC];
    bit ce [NC];

    // Reference model state
    bit m_flag;
    int m_pidx;
    int m_idx;
    int m_blink;

    // Expected outputs for the last pixel run
    logic [2:0] e_rgb;
    logic       e_col;
    logic [1:0] e_idx;
    logic       e_inv;

    function automatic bit in_box(input int c, input int p, input int s);
        return (c >= p) && (c < p + s);
    endfunction

    task automatic model_reset();
        m_flag = 0; m_pidx = 0; m_idx = 0; m_blink = 0;
    endtask

    // Spec-level evaluation of one pixel, then state update
    task automatic model_step(input int h, input int v, input logic [2:0] bg);
        bit vis, phit, any, shown, fe;
        int low;
        vis  = (h < H_DISPLAY) && (v < V_DISPLAY);
        fe   = (h == 0) && (v == V_DISPLAY);
        phit = in_box(h, px, PLAYER_WIDTH) && in_box(v, py, PLAYER_HEIGHT);
        any  = 0;
        low  = 0;
        for (int i = 0; i < NC; i++) begin
            if (!any && ce[i] && in_box(h, cx[i], CAR_WIDTH) && in_box(v, cy[i], CAR_HEIGHT)) begin
                any = 1;
                low = i;
            end
        end
        shown = !((m_blink != 0) && (((m_blink >> 2) & 1) == 1));
        if (!vis)               e_rgb = 3'b000;
        else if (phit && shown) e_rgb = P_RGB;
        else if (any)           e_rgb = C_RGB;
        else                    e_rgb = bg;
        e_col = 1'b0;
        if (vis && phit && any && m_blink == 0 && !m_flag) begin
            m_flag = 1;
            m_pidx = low;
        end
        if (fe) begin
            if (m_flag) begin
                e_col   = 1'b1;
                m_idx   = m_pidx;
                m_flag  = 0;
                m_blink = BF;
            end else if (m_blink != 0) begin
                m_blink = m_blink - 1;
            end
        end
        e_idx = 2'(m_idx);
        e_inv = (m_blink != 0);
    endtask

    // Present one pixel, flush it through both stages behind a neutral pixel, sample outputs
    task automatic run_pixel(input int h, input int v);
        player_x = 10'(px);
        player_y = 10'(py);
        for (int i = 0; i < NC; i++) begin
            car_x_bus[i*10 +: 10] = 10'(cx[i]);
            car_y_bus[i*10 +: 10] = 10'(cy[i]);
            car_en[i]             = ce[i];
        end
        h_count = 10'(h);
        v_count = 10'(v);
        model_step(h, v, bg_rgb);
        @(posedge CLK); #1;
        h_count = 10'd700;
        v_count = 10'd490;
        @(posedge CLK); #1;
    endtask

    task automatic place_off();
        px = 1000; py = 1000;
        for (int i = 0; i < NC; i++) begin
            cx[i] = 900; cy[i] = 900; ce[i] = 0;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #2;
        checks++; if (vga_rgb !== 3'b000) begin errors++; $display("FAIL reset_rgb got=%b want=000", vga_rgb); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision got=%b want=0", collision); end
        checks++; if (collision_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", collision_idx); end
        checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL reset_invuln got=%b want=0", invuln); end
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        $display("reset: outputs checked");
    endtask

    task automatic test_passthrough();
        int h, v;
        place_off();
        for (int n = 0; n < 8; n++) begin
            h = $urandom_range(0, H_DISPLAY - 1);
            v = $urandom_range(0, V_DISPLAY - 1);
            bg_rgb = 3'($urandom);
            run_pixel(h, v);
            checks++; if (vga_rgb !== e_rgb) begin errors++; $display("FAIL passthrough_rgb px=(%0d,%0d) got=%b want=%b", h, v, vga_rgb, e_rgb); end
            $display("passthrough: px=(%0d,%0d) rgb=%b", h, v, vga_rgb);
        end
        bg_rgb = 3'b101;
        run_pixel(100, 100);
        checks++; if (vga_rgb !== 3'b101) begin errors++; $display("FAIL passthrough_101 got=%b want=101", vga_rgb); end
        run_pixel(700, 100);
        checks++; if (vga_rgb !== 3'b000) begin errors++; $display("FAIL blank_h700 got=%b want=000", vga_rgb); end
        $display("passthrough: h=700 rgb=%b", vga_rgb);
    endtask

    task automatic test_priority();
        place_off();
        bg_rgb = 3'b001;
        px = 100; py = 200; cx[2] = 100; cy[2] = 200; ce[2] = 1;
        run_pixel(105, 205);
        checks++; if (vga_rgb !== P_RGB || e_rgb !== P_RGB) begin errors++; $display("FAIL prio_player got=%b want=%b", vga_rgb, P_RGB); end
        $display("priority: player+car2 rgb=%b", vga_rgb);
        px = 500; py = 400;
        run_pixel(105, 205);
        checks++; if (vga_rgb !== C_RGB) begin errors++; $display("FAIL prio_car got=%b want=%b", vga_rgb, C_RGB); end
        $display("priority: car2 only rgb=%b", vga_rgb);
        ce[2] = 0;
        run_pixel(105, 205);
        checks++; if (vga_rgb !== 3'b001) begin errors++; $display("FAIL prio_bg got=%b want=001", vga_rgb); end
        $display("priority: car2 disabled rgb=%b", vga_rgb);
    endtask

    // Frame ends with sprites off until the model's blink window has expired
    task automatic test_flush();
        place_off();
        for (int f = 0; f < BF + 3; f++) begin
            run_pixel(0, V_DISPLAY);
            checks++; if (collision !== e_col || collision_idx !== e_idx || invuln !== e_inv) begin
                errors++; $display("FAIL flush_frame%0d got=%b/%0d/%b want=%b/%0d/%b", f, collision, collision_idx, invuln, e_col, e_idx, e_inv);
            end
            $display("flush: frame %0d col=%b idx=%0d inv=%b", f, collision, collision_idx, invuln);
        end
    endtask

    task automatic test_collision_report();
        int pulses;
        place_off();
        pulses = 0;
        bg_rgb = 3'b000;
        px = 200; py = 100;
        cx[1] = 200; cy[1] = 100; ce[1] = 1;
        cx[3] = 200; cy[3] = 100; ce[3] = 1;
        for (int n = 0; n < 4; n++) begin
            run_pixel(200 + $urandom_range(0, 15), 100 + $urandom_range(0, 15));
            checks++; if (vga_rgb !== e_rgb || collision !== 1'b0) begin errors++; $display("FAIL coll_pixel got=%b/%b want=%b/0", vga_rgb, collision, e_rgb); end
        end
        run_pixel(0, V_DISPLAY);
        if (collision === 1'b1) pulses++;
        checks++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_pulse got=%b want=1", collision); end
        checks++; if (collision_idx !== 2'd1) begin errors++; $display("FAIL coll_idx got=%0d want=1", collision_idx); end
        checks++; if (invuln !== 1'b1) begin errors++; $display("FAIL coll_invuln got=%b want=1", invuln); end
        run_pixel(10, 10);
        if (collision === 1'b1) pulses++;
        checks++; if (pulses != 1) begin errors++; $display("FAIL coll_pulse_count got=%0d want=1", pulses); end
        $display("collision: pulses=%0d idx=%0d inv=%b", pulses, collision_idx, invuln);
    endtask

    task automatic test_invuln();
        int pulses;
        place_off();
        pulses = 0;
        px = 300; py = 300;
        cx[0] = 308; cy[0] = 300; ce[0] = 1;
        for (int f = 0; f < 2 * (BF + 1) + 1; f++) begin
            bg_rgb = 3'($urandom);
            run_pixel(301, 301);
            checks++; if (vga_rgb !== e_rgb) begin errors++; $display("FAIL inv_player_only f=%0d got=%b want=%b", f, vga_rgb, e_rgb); end
            run_pixel(310, 305);
            checks++; if (vga_rgb !== e_rgb) begin errors++; $display("FAIL inv_overlap f=%0d got=%b want=%b", f, vga_rgb, e_rgb); end
            run_pixel($urandom_range(290, 330), $urandom_range(290, 330));
            checks++; if (vga_rgb !== e_rgb) begin errors++; $display("FAIL inv_random f=%0d got=%b want=%b", f, vga_rgb, e_rgb); end
            run_pixel(0, V_DISPLAY);
            if (collision === 1'b1) pulses++;
            checks++; if (collision !== e_col || invuln !== e_inv || collision_idx !== e_idx) begin
                errors++; $display("FAIL inv_frame f=%0d got=%b/%b/%0d want=%b/%b/%0d", f, collision, invuln, collision_idx, e_col, e_inv, e_idx);
            end
            $display("invuln: frame %0d col=%b inv=%b", f, collision, invuln);
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL inv_pulse_count got=%0d want=3", pulses); end
    endtask

    task automatic test_wrap();
        place_off();
        bg_rgb = 3'b011;
        cx[0] = 1020; cy[0] = 50; ce[0] = 1;
        for (int h = 0; h <= 10; h++) begin
            run_pixel(h, 55);
            checks++; if (vga_rgb !== 3'b011) begin errors++; $display("FAIL wrap h=%0d got=%b want=011", h, vga_rgb); end
            $display("wrap: h=%0d rgb=%b", h, vga_rgb);
        end
    endtask

    task automatic test_reset_mid_frame();
        test_flush();
        place_off();
        px = 50; py = 100; cx[2] = 50; cy[2] = 100; ce[2] = 1;
        run_pixel(55, 100);
        checks++; if (vga_rgb !== P_RGB) begin errors++; $display("FAIL rstmid_overlap got=%b want=%b", vga_rgb, P_RGB); end
        place_off();
        run_pixel(20, 300);
        RST = 1'b1;
        #2;
        checks++; if (vga_rgb !== 3'b000 || collision !== 1'b0 || collision_idx !== 2'd0 || invuln !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs got=%b/%b/%0d/%b want=000/0/0/0", vga_rgb, collision, collision_idx, invuln);
        end
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        run_pixel(30, 310);
        run_pixel(0, V_DISPLAY);
        checks++; if (collision !== 1'b0 || collision !== e_col) begin errors++; $display("FAIL rstmid_no_pulse got=%b want=0", collision); end
        checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL rstmid_invuln got=%b want=0", invuln); end
        $display("reset_mid_frame: col=%b inv=%b", collision, invuln);
    endtask

    initial begin
        place_off();
        model_reset();
        test_reset();
        test_passthrough();
        test_priority();
        test_flush();
        test_collision_report();
        test_flush();
        test_invuln();
        test_flush();
        test_wrap();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
